// File: rtl/sid_pkg.sv
// Shared SID audio-path types and I2S frame constants.
package sid_pkg;

  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int I2S_DATA_BITS  = 24;
  localparam int I2S_PAD_BITS   = I2S_SLOT_BITS - I2S_DATA_BITS;

  typedef logic signed [I2S_DATA_BITS-1:0] s24_t;
  typedef logic [I2S_FRAME_BITS-1:0]       i2s_frame_t;

  // Left slot in the upper half, each sample MSB-justified with zero padding.
  function automatic i2s_frame_t i2s_pack_frame(input s24_t l, input s24_t r);
    return {l, {I2S_PAD_BITS{1'b0}}, r, {I2S_PAD_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/sid_i2s_clkgen.sv
// BCLK generator: divides clk by 2*CLK_DIV and flags the cycle whose edge drops BCLK.
module sid_i2s_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic bclk_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic       bclk_q, bclk_d;
  logic       wrap;

  assign wrap = (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + 8'd1;
    bclk_d    = bclk_q;
    if (wrap) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

  // Combinational so the data path updates on the same edge that lowers BCLK.
  assign fall_o = wrap & bclk_q;
  assign bclk_o = bclk_q;

endmodule

// File: rtl/sid_i2s_tx.sv
// Philips I2S transmitter: holds the latest stereo sample and serializes 24-in-32 bit slots.
module sid_i2s_tx
  import sid_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [23:0] audio_l_i,
  input  logic signed [23:0] audio_r_i,
  input  logic               valid_i,
  output logic               taken_o,
  output logic               overrun_o,
  output logic               i2s_bclk,
  output logic               i2s_lrclk,
  output logic               i2s_dout
);

  logic       fall;
  logic       frame_load;

  logic [5:0] bit_cnt_q, bit_cnt_d;
  logic       lrclk_q, lrclk_d;
  logic       dout_q, dout_d;
  logic       taken_q, taken_d;
  logic       overrun_q, overrun_d;
  logic       pending_q, pending_d;
  s24_t       hold_l_q, hold_l_d;
  s24_t       hold_r_q, hold_r_d;
  i2s_frame_t shifter_q, shifter_d;

  sid_i2s_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk    (clk),
    .rst    (rst),
    .bclk_o (i2s_bclk),
    .fall_o (fall)
  );

  assign frame_load = fall && (bit_cnt_q == 6'd63);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    lrclk_d   = lrclk_q;
    dout_d    = dout_q;
    taken_d   = 1'b0;
    overrun_d = overrun_q;
    pending_d = pending_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    shifter_d = shifter_q;

    if (fall) begin
      bit_cnt_d = bit_cnt_q + 6'd1;
      lrclk_d   = bit_cnt_d[5];
      if (frame_load) begin
        // dout carries the last pad bit of the outgoing frame, giving the one-BCLK I2S delay.
        shifter_d = i2s_pack_frame(hold_l_q, hold_r_q);
        pending_d = 1'b0;
        taken_d   = 1'b1;
        dout_d    = 1'b0;
      end else begin
        dout_d    = shifter_q[I2S_FRAME_BITS-1];
        shifter_d = {shifter_q[I2S_FRAME_BITS-2:0], 1'b0};
      end
    end

    // A sample arriving on the load cycle is kept for the next frame, not lost.
    if (valid_i) begin
      hold_l_d  = audio_l_i;
      hold_r_d  = audio_r_i;
      pending_d = 1'b1;
      if (pending_q && !frame_load) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= 6'd63;
      lrclk_q   <= 1'b1;
      dout_q    <= 1'b0;
      taken_q   <= 1'b0;
      overrun_q <= 1'b0;
      pending_q <= 1'b0;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      shifter_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      lrclk_q   <= lrclk_d;
      dout_q    <= dout_d;
      taken_q   <= taken_d;
      overrun_q <= overrun_d;
      pending_q <= pending_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      shifter_q <= shifter_d;
    end
  end

  assign i2s_lrclk = lrclk_q;
  assign i2s_dout  = dout_q;
  assign taken_o   = taken_q;
  assign overrun_o = overrun_q;

endmodule
